dram_read_streamer: RTL and testbench
=====================================

Name: dram_read_streamer

Overview:
- Upstream stage of the DRAM-to-CRAM swizzle.
- Issues a run of single-word read requests to the memory controller and buffers the responses in a small FIFO.
- Delivers the data as a gap-tolerant stream on data_out/data_valid, which connect directly to the swizzle's mem_ctrl_data_in/data_valid.
- Credit-based issue ensures response data is never dropped, because the swizzle applies no backpressure.

Parameters:
- DWIDTH, 40, data word width; equals MEM_CTRL_DWIDTH.
- AWIDTH, 16, DRAM word address width.
- CWIDTH, 16, word-count width.
- FIFO_DEPTH, 8, response FIFO depth; power of two, at least 2.
- LOG_FIFO_DEPTH, 3, log2(FIFO_DEPTH).

Ports:
- clk, input, 1, clock.
- resetn, input, 1, reset; synchronous, active-low.
- start, input, 1, one-cycle command strobe; sampled only in IDLE.
- base_addr, input, AWIDTH, first DRAM word address; latched on start.
- num_words, input, CWIDTH, number of words to fetch; latched on start.
- rd_req_valid, output, 1, read request valid.
- rd_req_ready, input, 1, memory controller accepts the request.
- rd_req_addr, output, AWIDTH, read request address.
- rd_resp_valid, input, 1, read data valid; in order, no backpressure.
- rd_resp_data, input, DWIDTH, read data.
- data_out, output, DWIDTH, streamed word to the swizzle.
- data_valid, output, 1, data_out valid this cycle.
- busy, output, 1, command in progress.
- done, output, 1, one-cycle pulse when the command has completed.
- err, output, 1, sticky flag: a response arrived with no request outstanding.

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; every output 0 (rd_req_addr=0, data_out=0). Outstanding count, remaining counts and FIFO pointers are cleared.
- Reset mid-operation aborts the command. The memory controller must be quiesced externally; any stale response arriving after reset sets err and is dropped.
- States: IDLE, ISSUE, DRAIN.
- IDLE + start with num_words>0:
  - Latch the address into the request address register and req_left=deliver_left=num_words.
  - Go to ISSUE; busy=1 from the next cycle.
- IDLE + start with num_words==0: done=1 in the next cycle; stay IDLE; busy stays 0.
- start outside IDLE is ignored.
- Credits are FIFO_DEPTH - fifo_count - outstanding, each term (LOG_FIFO_DEPTH+1) bits wide.
- rd_req_valid=1 in ISSUE when req_left>0 and credits>0.
- Once rd_req_valid is raised, it and rd_req_addr stay stable until rd_req_valid & rd_req_ready. This is guaranteed because only an issue reduces credits.
- Request handshake:
  - rd_req_addr increments by 1, wrapping modulo 2^AWIDTH.
  - req_left decrements and outstanding increments.
  - When req_left reaches 0, go to DRAIN.
- Response with outstanding>0: push into the FIFO; outstanding decrements.
- Response with outstanding==0: set err and drop the data.
- Handshake and response in the same cycle leave outstanding unchanged.
- FIFO overflow is impossible by construction.
- Output: whenever the FIFO is non-empty, pop one word per cycle into the data_out register, set data_valid=1 for that cycle and decrement deliver_left.
- Latency: a response sampled at edge k into an empty FIFO produces data_valid=1 in the cycle following edge k+1 (two edges).
- Back-to-back responses give back-to-back data_valid. data_out holds its last value when data_valid=0.
- Completion: the edge that pops the last word (deliver_left 1 to 0) goes to IDLE. done=1 and busy=0 in the cycle after the last data_valid.
- A new start is accepted in the same cycle as done.
- err clears only on reset.

Decomposition:
- Shared include header: DWIDTH/AWIDTH/CWIDTH defines matching MEM_CTRL_DWIDTH, and state encodings (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2).
- One sub-module, stream_fifo: synchronous FIFO parameterised on width and depth, with push, pop, count, empty and registered data out. The top level holds the FSM, counters and credit logic.

Test Plan:
- start, base_addr=0x0100, num_words=5, rd_req_ready=1, responses returned 3 cycles after each request -> addresses 0x0100 to 0x0104 issued in order; five data_valid pulses carrying the response data in order; done one cycle after the fifth pulse; err=0.
- num_words=20, responses withheld for 30 cycles -> at most 8 requests issued (rd_req_valid drops with credits=0); after responses resume, all 20 delivered in order with no loss.
- rd_req_ready held 0 for 10 cycles with a request pending -> rd_req_valid=1 and rd_req_addr constant throughout; handshake completes when ready rises.
- base_addr=0xFFFE, num_words=4 -> request addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- start with num_words=0 -> done pulse next cycle, no requests issued; a rd_resp_valid pulse while IDLE -> err=1 stays set until resetn=0.
- resetn=0 for one cycle while in ISSUE with 3 words outstanding -> all outputs 0, state IDLE; a new start with num_words=2 then completes normally.

Source files
------------

// File: rtl/dram_read_streamer_pkg.sv
// Shared widths and state encoding for the DRAM read streamer, the stage that
// feeds the DRAM-to-CRAM swizzle.
package dram_read_streamer_pkg;

  // Data width must track the memory controller data width.
  localparam int MEM_CTRL_DWIDTH    = 40;
  localparam int DRS_DWIDTH         = MEM_CTRL_DWIDTH;
  localparam int DRS_AWIDTH         = 16;
  localparam int DRS_CWIDTH         = 16;
  localparam int DRS_FIFO_DEPTH     = 8;
  localparam int DRS_LOG_FIFO_DEPTH = 3;

  // Command sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } drs_state_t;

endpackage

// File: rtl/dram_read_streamer_stream_fifo.sv
// Synchronous response FIFO with a registered read port. A pop loads the head
// entry into dout_o on the clock edge; dout_o holds its value otherwise.
// A push into a full FIFO and a pop from an empty FIFO are both ignored.
module stream_fifo #(
  parameter int WIDTH     = 40,
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   din_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   dout_o,
  output logic [LOG_DEPTH:0] count_o,
  output logic               empty_o
);

  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);

  // Next-state for pointers, occupancy and the registered read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (LOG_DEPTH + 1)'(1);
      2'b01:   count_d = count_q - (LOG_DEPTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dram_read_streamer.sv
// DRAM read streamer: issues a run of single-word reads, buffers responses in
// a small FIFO and streams them to the swizzle without backpressure.
//
// Request handshake: rd_req_valid/rd_req_addr are held stable once raised
// until the cycle where rd_req_valid & rd_req_ready, which is the transfer.
// Responses (rd_resp_valid) and output words (data_valid) are push-only
// strobes with no ready: the issue side only requests what the FIFO is
// guaranteed to hold (credits = depth - occupancy - outstanding).
module dram_read_streamer
  import dram_read_streamer_pkg::*;
#(
  parameter int DWIDTH         = DRS_DWIDTH,
  parameter int AWIDTH         = DRS_AWIDTH,
  parameter int CWIDTH         = DRS_CWIDTH,
  parameter int FIFO_DEPTH     = DRS_FIFO_DEPTH,
  parameter int LOG_FIFO_DEPTH = DRS_LOG_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [CWIDTH-1:0] num_words,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [AWIDTH-1:0] rd_req_addr,
  input  logic              rd_resp_valid,
  input  logic [DWIDTH-1:0] rd_resp_data,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNTW = LOG_FIFO_DEPTH + 1;
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

  drs_state_t        state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [CWIDTH-1:0] req_left_q, req_left_d;
  logic [CWIDTH-1:0] deliver_left_q, deliver_left_d;
  logic [CNTW-1:0]   outstanding_q, outstanding_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              fin_q, fin_d;
  logic              data_valid_q, data_valid_d;

  logic [CNTW-1:0]   fifo_count;
  logic [CNTW-1:0]   credits;
  logic              fifo_empty;
  logic              req_fire;
  logic              resp_push;
  logic              resp_stray;
  logic              pop;

  // Credits only shrink on an issue, so a raised request never loses its slot.
  assign credits      = DEPTH_CNT - fifo_count - outstanding_q;
  assign rd_req_valid = (state_q == ST_ISSUE) && (req_left_q != '0) && (credits != '0);
  assign req_fire     = rd_req_valid && rd_req_ready;
  assign resp_push    = rd_resp_valid && (outstanding_q != '0);
  assign resp_stray   = rd_resp_valid && (outstanding_q == '0);
  assign pop          = !fifo_empty;

  stream_fifo #(
    .WIDTH    (DWIDTH),
    .DEPTH    (FIFO_DEPTH),
    .LOG_DEPTH(LOG_FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push_i (resp_push),
    .din_i  (rd_resp_data),
    .pop_i  (pop),
    .dout_o (data_out),
    .count_o(fifo_count),
    .empty_o(fifo_empty)
  );

  // FSM next-state plus counter, credit and status updates.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    req_left_d     = req_left_q;
    deliver_left_d = deliver_left_q;
    outstanding_d  = outstanding_q;
    err_d          = err_q | resp_stray;
    done_d         = fin_q;
    fin_d          = 1'b0;
    data_valid_d   = pop;

    case ({req_fire, resp_push})
      2'b10:   outstanding_d = outstanding_q + CNTW'(1);
      2'b01:   outstanding_d = outstanding_q - CNTW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (pop) begin
      deliver_left_d = deliver_left_q - CWIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_d        = ST_ISSUE;
            addr_d         = base_addr;
            req_left_d     = num_words;
            deliver_left_d = num_words;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (req_fire) begin
          addr_d     = addr_q + AWIDTH'(1);
          req_left_d = req_left_q - CWIDTH'(1);
          if (req_left_q == CWIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The pop of the final word ends the command; done follows the
        // resulting data_valid by one cycle via fin_q.
        if (pop && (deliver_left_q == CWIDTH'(1))) begin
          state_d = ST_IDLE;
          fin_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      req_left_q     <= '0;
      deliver_left_q <= '0;
      outstanding_q  <= '0;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
      fin_q          <= 1'b0;
      data_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      req_left_q     <= req_left_d;
      deliver_left_q <= deliver_left_d;
      outstanding_q  <= outstanding_d;
      err_q          <= err_d;
      done_q         <= done_d;
      fin_q          <= fin_d;
      data_valid_q   <= data_valid_d;
    end
  end

  assign rd_req_addr = addr_q;
  assign data_valid  = data_valid_q;
  assign busy        = (state_q != ST_IDLE) || fin_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dram_read_streamer.sv
// Directed bench for dram_read_streamer. A memory-controller model answers
// each accepted request a fixed number of cycles later; a stream model holds
// the words each command must deliver, in order, and the expected status.
module tb_dram_read_streamer;

  localparam int DW = 40;
  localparam int AW = 16;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic          rd_req_valid;
  logic          rd_req_ready = 1'b1;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid = 1'b0;
  logic [DW-1:0] rd_resp_data = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  dram_read_streamer dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // ---------------- scoreboard / model state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];          // words still to be delivered, in order
  logic [AW-1:0] pend_addr[$];      // memory model: accepted, unanswered requests
  int unsigned   pend_due[$];
  int unsigned   cyc = 0;
  logic          exp_done = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_err  = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  bit            hold_resp = 1'b0;
  int            issued = 0;
  int            delivered = 0;

  // Contents of DRAM word a, as returned by the memory model.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'h5A, a, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One clock: compare outputs at the falling edge, then drive the memory model.
  task automatic step();
    logic          hs;
    logic [AW-1:0] hs_addr;
    // Request outputs are stable between edges; inputs are already set up.
    hs      = resetn && rd_req_valid && rd_req_ready;
    hs_addr = rd_req_addr;
    @(negedge clk);
    cyc++;
    check("done", done, exp_done);
    check("busy", busy, exp_busy);
    check("err", err, exp_err);
    exp_done = 1'b0;
    if (hs) begin
      check("req_addr", hs_addr, exp_addr);
      exp_addr = exp_addr + AW'(1);
      issued++;
      pend_addr.push_back(hs_addr);
      pend_due.push_back(cyc + 2);  // sampled by the DUT three edges after the handshake
    end
    if (data_valid) begin
      delivered++;
      if (exp_q.size() == 0) begin
        fail_now("data_valid with no word expected");
      end else begin
        check("data_out", data_out, exp_q.pop_front());
        if (exp_q.size() == 0 && exp_busy) begin
          exp_done = 1'b1;
          exp_busy = 1'b0;
        end
      end
    end
    start         = 1'b0;
    rd_resp_valid = 1'b0;
    if (!hold_resp && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      rd_resp_valid = 1'b1;
      rd_resp_data  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cmd(input logic [AW-1:0] base, input logic [CW-1:0] n);
    start     = 1'b1;
    base_addr = base;
    num_words = n;
    if (n == '0) begin
      exp_done = 1'b1;
    end else begin
      exp_busy = 1'b1;
      exp_addr = base;
      for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_word(base + AW'(i)));
    end
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_busy || exp_done) && k < budget) begin
      step();
      k++;
    end
    if (exp_busy || exp_done) fail_now({name, " timeout"});
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    rd_resp_valid = 1'b0;
    exp_q.delete();
    pend_addr.delete();
    pend_due.delete();
    exp_done = 1'b0;
    exp_busy = 1'b0;
    exp_err  = 1'b0;
    step();
    check("rst_req_valid", rd_req_valid, 0);
    check("rst_req_addr", rd_req_addr, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int i0;
    int d0;
    int k;

    do_reset();
    step();

    // 1: five words from 0x0100, responses three cycles after each request.
    i0 = issued; d0 = delivered;
    cmd(16'h0100, 16'd5);
    run_until_idle(100, "t1");
    check("t1_requests", issued - i0, 5);
    check("t1_pulses", delivered - d0, 5);
    check("t1_last_word", data_out, 40'h5A_0104_FEFB);
    check("t1_err", err, 0);

    // 2: twenty words with responses withheld: credits cap issue at eight.
    hold_resp = 1'b1;
    step();
    i0 = issued; d0 = delivered;
    cmd(16'h0200, 16'd20);
    repeat (30) step();
    check("t2_capped_requests", issued - i0, 8);
    check("t2_req_valid_low", rd_req_valid, 0);
    check("t2_no_output", delivered - d0, 0);
    hold_resp = 1'b0;
    run_until_idle(400, "t2");
    check("t2_requests", issued - i0, 20);
    check("t2_pulses", delivered - d0, 20);
    check("t2_last_word", data_out, 40'h5A_0213_FDEC);

    // 3: ready held low for ten cycles with a request pending.
    rd_req_ready = 1'b0;
    step();
    i0 = issued;
    cmd(16'h0300, 16'd3);
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      check("t3_req_valid_held", rd_req_valid, 1);
      check("t3_req_addr_held", rd_req_addr, 16'h0300);
    end
    check("t3_no_handshake", issued - i0, 0);
    rd_req_ready = 1'b1;
    run_until_idle(100, "t3");
    check("t3_requests", issued - i0, 3);
    check("t3_last_word", data_out, 40'h5A_0302_FCFD);

    // 4: address wrap 0xFFFE, 0xFFFF, 0x0000, 0x0001.
    step();
    i0 = issued;
    cmd(16'hFFFE, 16'd4);
    run_until_idle(100, "t4");
    check("t4_requests", issued - i0, 4);
    check("t4_last_addr_reg", rd_req_addr, 16'h0002);
    check("t4_last_word", data_out, 40'h5A_0001_FFFE);

    // 5: zero-length command, then a stray response while idle.
    step();
    i0 = issued;
    cmd(16'h0700, 16'd0);
    step();
    check("t5_done_pulse", done, 1);
    check("t5_busy", busy, 0);
    step();
    check("t5_done_single", done, 0);
    check("t5_no_requests", issued - i0, 0);
    rd_resp_valid = 1'b1;
    rd_resp_data  = 40'hDE_ADBE_EF00;
    exp_err       = 1'b1;
    step();
    check("t5_err_set", err, 1);
    repeat (5) step();
    check("t5_err_sticky", err, 1);
    do_reset();

    // 6: reset in ISSUE with three requests outstanding, then a fresh command.
    hold_resp = 1'b1;
    step();
    i0 = issued;
    cmd(16'h0400, 16'd10);
    k = 0;
    while (issued - i0 < 3 && k < 20) begin
      step();
      k++;
    end
    check("t6_outstanding", issued - i0, 3);
    check("t6_busy_before_reset", busy, 1);
    do_reset();
    hold_resp = 1'b0;
    step();
    i0 = issued; d0 = delivered;
    cmd(16'h0500, 16'd2);
    run_until_idle(100, "t6");
    check("t6_requests", issued - i0, 2);
    check("t6_pulses", delivered - d0, 2);
    check("t6_last_word", data_out, 40'h5A_0501_FAFE);
    check("t6_err", err, 0);
    repeat (3) step();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
